// File: rtl/ps2_host_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ps2_host_tx : PS/2 host-to-device byte transmitter (inhibit, request,       |
// |               11-bit frame, ACK check, timeout)                             |
// | Revision    : 1.0                                                           |
// +----------------------------------------------------------------------------+
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 12000,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic       clk_in,
  input  logic       reset_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clock,
  input  logic       ps2_data,
  output logic       ps2_clock_drive_low,
  output logic       ps2_data_drive_low,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_error
);

  localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    INHIBIT   = 3'd1,
    REQUEST   = 3'd2,
    SHIFT     = 3'd3,
    ACK       = 3'd4,
    WAIT_IDLE = 3'd5
  } state_t;

  state_t           r_state;
  logic [1:0]       r_clk_sync;
  logic [1:0]       r_data_sync;
  logic             r_clk_prev;
  logic [9:0]       r_frame;
  logic [3:0]       r_bit_idx;
  logic [INH_W-1:0] r_inh_cnt;
  logic [TMO_W-1:0] r_tmo_cnt;
  logic             w_fall;

  assign w_fall   = r_clk_prev & ~r_clk_sync[1];
  assign tx_ready = (r_state == IDLE);
  assign busy     = (r_state != IDLE);

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      r_clk_sync  <= 2'b11;
      r_data_sync <= 2'b11;
      r_clk_prev  <= 1'b1;
    end else begin
      r_clk_sync  <= {r_clk_sync[0], ps2_clock};
      r_data_sync <= {r_data_sync[0], ps2_data};
      r_clk_prev  <= r_clk_sync[1];
    end
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      r_state             <= IDLE;
      r_frame             <= '0;
      r_bit_idx           <= '0;
      r_inh_cnt           <= '0;
      r_tmo_cnt           <= '0;
      ps2_clock_drive_low <= 1'b0;
      ps2_data_drive_low  <= 1'b0;
      tx_done             <= 1'b0;
      tx_error            <= 1'b0;
    end else begin
      tx_done  <= 1'b0;
      tx_error <= 1'b0;
      case (r_state)
        IDLE: begin
          ps2_clock_drive_low <= 1'b0;
          ps2_data_drive_low  <= 1'b0;
          if (tx_valid) begin
            // frame shifts out LSB first: data, odd parity, stop
            r_frame             <= {1'b1, ~^tx_data, tx_data};
            r_inh_cnt           <= '0;
            ps2_clock_drive_low <= 1'b1;
            r_state             <= INHIBIT;
          end
        end
        INHIBIT: begin
          if (r_inh_cnt == INH_LAST) begin
            ps2_clock_drive_low <= 1'b0;
            ps2_data_drive_low  <= 1'b1;
            r_tmo_cnt           <= '0;
            r_state             <= REQUEST;
          end else begin
            r_inh_cnt <= r_inh_cnt + INH_W'(1);
          end
        end
        default: begin
          // timeout wins over a falling edge seen on the same cycle
          if (r_tmo_cnt == TMO_LAST) begin
            ps2_clock_drive_low <= 1'b0;
            ps2_data_drive_low  <= 1'b0;
            tx_error            <= 1'b1;
            r_state             <= IDLE;
          end else begin
            r_tmo_cnt <= w_fall ? '0 : r_tmo_cnt + TMO_W'(1);
            case (r_state)
              REQUEST: begin
                if (w_fall) begin
                  ps2_data_drive_low <= ~r_frame[0];
                  r_frame            <= r_frame >> 1;
                  r_bit_idx          <= 4'd1;
                  r_state            <= SHIFT;
                end
              end
              SHIFT: begin
                if (w_fall) begin
                  ps2_data_drive_low <= ~r_frame[0];
                  r_frame            <= r_frame >> 1;
                  r_bit_idx          <= r_bit_idx + 4'd1;
                  if (r_bit_idx == 4'd9) r_state <= ACK;
                end
              end
              ACK: begin
                if (w_fall) begin
                  if (!r_data_sync[1]) begin
                    r_state <= WAIT_IDLE;
                  end else begin
                    tx_error <= 1'b1;
                    r_state  <= IDLE;
                  end
                end
              end
              WAIT_IDLE: begin
                if (r_clk_sync[1] && r_data_sync[1]) begin
                  tx_done <= 1'b1;
                  r_state <= IDLE;
                end
              end
              default: begin
                ps2_clock_drive_low <= 1'b0;
                ps2_data_drive_low  <= 1'b0;
                r_state             <= IDLE;
              end
            endcase
          end
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ps2_host_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_ps2_host_tx : directed bench for ps2_host_tx with a simple device model  |
// | Revision       : 1.0                                                        |
// +----------------------------------------------------------------------------+
module tb_ps2_host_tx;

  logic       clk_in = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       ps2_clock;
  logic       ps2_data;
  logic       ps2_clock_drive_low;
  logic       ps2_data_drive_low;
  logic       busy;
  logic       tx_done;
  logic       tx_error;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;

  int         vectors = 0;
  int         miscompares = 0;
  int         done_cnt = 0;
  int         err_cnt = 0;
  int         both_cnt = 0;
  int         inh_len = 0;
  int         bit_idx = 0;
  int         done0, err0, n;
  logic [10:0] frame;

  assign ps2_clock = ~(ps2_clock_drive_low | dev_clk_low);
  assign ps2_data  = ~(ps2_data_drive_low | dev_data_low);

  always #5 clk_in = ~clk_in;

  ps2_host_tx #(.INHIBIT_CYCLES(20), .TIMEOUT_CYCLES(400)) dut (
    .clk_in              (clk_in),
    .reset_n             (reset_n),
    .tx_data             (tx_data),
    .tx_valid            (tx_valid),
    .tx_ready            (tx_ready),
    .ps2_clock           (ps2_clock),
    .ps2_data            (ps2_data),
    .ps2_clock_drive_low (ps2_clock_drive_low),
    .ps2_data_drive_low  (ps2_data_drive_low),
    .busy                (busy),
    .tx_done             (tx_done),
    .tx_error            (tx_error)
  );

  always @(posedge clk_in) begin
    if (tx_done)             done_cnt <= done_cnt + 1;
    if (tx_error)            err_cnt  <= err_cnt + 1;
    if (tx_done && tx_error) both_cnt <= both_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // offer a byte, measure how long the host inhibits, capture the start bit
  task automatic begin_tx(input logic [7:0] b, input bit hold);
    @(negedge clk_in);
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge clk_in);
    if (!hold) tx_valid = 1'b0;
    inh_len = 0;
    while (ps2_clock_drive_low === 1'b1 && inh_len < 100) begin
      inh_len++;
      @(negedge clk_in);
    end
    frame    = '0;
    frame[0] = ps2_data;
    bit_idx  = 1;
  endtask

  // device generates clock pulses, reading the data line on each rising edge
  task automatic dev_clocks(input int cnt);
    for (int i = 0; i < cnt; i++) begin
      repeat (40) @(negedge clk_in);
      dev_clk_low = 1'b1;
      repeat (40) @(negedge clk_in);
      dev_clk_low = 1'b0;
      if (bit_idx < 11) frame[bit_idx] = ps2_data;
      bit_idx++;
    end
  endtask

  task automatic dev_ack(input bit ack);
    repeat (40) @(negedge clk_in);
    if (ack) dev_data_low = 1'b1;
    repeat (5) @(negedge clk_in);
    dev_clk_low = 1'b1;
    repeat (40) @(negedge clk_in);
    dev_clk_low = 1'b0;
    repeat (10) @(negedge clk_in);
    dev_data_low = 1'b0;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 300 && tx_ready !== 1'b1; k++) @(negedge clk_in);
    repeat (3) @(negedge clk_in);
  endtask

  task automatic xfer(input logic [7:0] b, input bit ack);
    begin_tx(b, 1'b0);
    dev_clocks(10);
    dev_ack(ack);
    wait_idle();
  endtask

  initial begin
    // reset state
    repeat (3) @(negedge clk_in);
    chk("rst_tx_ready", tx_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_clk_drv", ps2_clock_drive_low, 0);
    chk("rst_dat_drv", ps2_data_drive_low, 0);
    chk("rst_pulses", {tx_done, tx_error}, 0);
    reset_n = 1'b1;
    repeat (3) @(negedge clk_in);

    // 0xED with ACK
    done0 = done_cnt; err0 = err_cnt;
    begin_tx(8'hED, 1'b0);
    chk("ed_inhibit_len", inh_len, 20);
    chk("ed_start_drive", ps2_data_drive_low, 1);
    chk("ed_busy", busy, 1);
    chk("ed_tx_ready_busy", tx_ready, 0);
    dev_clocks(10);
    chk("ed_frame", frame, 11'h7DA);
    dev_ack(1'b1);
    wait_idle();
    chk("ed_done_cnt", done_cnt - done0, 1);
    chk("ed_err_cnt", err_cnt - err0, 0);
    chk("ed_tx_ready", tx_ready, 1);

    // parity corners
    xfer(8'h00, 1'b1);
    chk("p00_frame", frame, 11'h600);
    chk("p00_parity", frame[9], 1);
    xfer(8'hFF, 1'b1);
    chk("pff_frame", frame, 11'h7FE);
    chk("pff_parity", frame[9], 1);
    xfer(8'h01, 1'b1);
    chk("p01_frame", frame, 11'h402);
    chk("p01_parity", frame[9], 0);

    // device never clocks: timeout 400 cycles after REQUEST entry
    done0 = done_cnt; err0 = err_cnt;
    begin_tx(8'h55, 1'b0);
    n = 0;
    while (tx_error !== 1'b1 && n < 1000) begin
      @(negedge clk_in);
      n++;
    end
    chk("tmo_latency", n, 400);
    chk("tmo_drives", {ps2_clock_drive_low, ps2_data_drive_low}, 0);
    repeat (3) @(negedge clk_in);
    chk("tmo_err_cnt", err_cnt - err0, 1);
    chk("tmo_done_cnt", done_cnt - done0, 0);

    // device leaves data high on the 11th falling edge
    done0 = done_cnt; err0 = err_cnt;
    xfer(8'hAA, 1'b0);
    chk("noack_err_cnt", err_cnt - err0, 1);
    chk("noack_done_cnt", done_cnt - done0, 0);
    chk("noack_idle", tx_ready, 1);
    chk("noack_drives", {ps2_clock_drive_low, ps2_data_drive_low}, 0);

    // reset while bit 4 (a zero) is driven
    done0 = done_cnt; err0 = err_cnt;
    begin_tx(8'h0F, 1'b0);
    dev_clocks(5);
    chk("rstmid_bit4_drive", ps2_data_drive_low, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("rstmid_drives", {ps2_clock_drive_low, ps2_data_drive_low}, 0);
    chk("rstmid_busy", busy, 0);
    repeat (5) @(negedge clk_in);
    chk("rstmid_pulses", (done_cnt - done0) + (err_cnt - err0), 0);
    reset_n = 1'b1;
    repeat (3) @(negedge clk_in);
    done0 = done_cnt;
    xfer(8'hF4, 1'b1);
    chk("f4_frame", frame, 11'h5E8);
    chk("f4_done_cnt", done_cnt - done0, 1);

    // tx_valid held, tx_data changed mid-transfer
    done0 = done_cnt;
    begin_tx(8'h96, 1'b1);
    chk("hold_inhibit_len", inh_len, 20);
    tx_data = 8'h11;
    dev_clocks(10);
    chk("hold_not_ready", tx_ready, 0);
    chk("hold_frame", frame, 11'h72C);
    dev_ack(1'b1);
    n = 0;
    while (done_cnt == done0 && n < 300) begin
      @(negedge clk_in);
      n++;
    end
    chk("hold_done_cnt", done_cnt - done0, 1);
    n = 0;
    while (ps2_clock_drive_low !== 1'b1 && n < 10) begin
      @(negedge clk_in);
      n++;
    end
    chk("hold_reaccept", ps2_clock_drive_low, 1);
    tx_valid = 1'b0;
    n = 0;
    while (ps2_clock_drive_low === 1'b1 && n < 100) begin
      @(negedge clk_in);
      n++;
    end
    frame    = '0;
    frame[0] = ps2_data;
    bit_idx  = 1;
    dev_clocks(10);
    dev_ack(1'b1);
    wait_idle();
    chk("next_frame", frame, 11'h622);
    chk("next_done_cnt", done_cnt - done0, 2);

    chk("done_error_overlap", both_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 SHALL have parameter INHIBIT_CYCLES, default 12000, meaning the clk_in cycles the host holds PS/2 clock low before the request (120 us at 100 MHz).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 2000000, meaning the maximum clk_in cycles between consecutive device clock falling edges, or from request to first edge (20 ms).
REQ-003 SHALL have port clk_in  input  1  system clock (100 MHz).
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port tx_data  input  8  command byte to send.
REQ-006 SHALL have port tx_valid  input  1  byte offered.
REQ-007 SHALL have port tx_ready  output  1  block can accept a byte.
REQ-008 SHALL have port ps2_clock  input  1  PS/2 clock line level, asynchronous.
REQ-009 SHALL have port ps2_data  input  1  PS/2 data line level, asynchronous.
REQ-010 SHALL have port ps2_clock_drive_low  output  1  open-drain enable; 1 pulls clock low.
REQ-011 SHALL have port ps2_data_drive_low  output  1  open-drain enable; 1 pulls data low.
REQ-012 SHALL have port busy  output  1  transfer in progress; the keyboard receiver ignores the bus while high.
REQ-013 SHALL have port tx_done  output  1  one-cycle pulse: byte acknowledged by device.
REQ-014 SHALL have port tx_error  output  1  one-cycle pulse: timeout or missing ACK.

Function
REQ-015 SHALL synchronise ps2_clock and ps2_data through two flip-flops each, and SHALL detect a falling edge as synchronised clock previous=1, current=0.
REQ-016 SHALL implement states IDLE, INHIBIT, REQUEST, SHIFT, ACK and WAIT_IDLE.
REQ-017 SHALL hold tx_ready=1 only in IDLE; a byte is accepted on a cycle where tx_valid=1 and tx_ready=1; tx_data is latched on that cycle and the FSM moves to INHIBIT.
REQ-018 SHALL compute parity as odd parity: parity = NOT XOR of the latched byte.
REQ-019 INHIBIT: clock_drive_low=1, data_drive_low=0, for exactly INHIBIT_CYCLES cycles; the FSM then moves to REQUEST.
REQ-020 REQUEST: clock_drive_low=0, data_drive_low=1 (start bit); on the first falling edge, drive data bit0, set bit index=1 and move to SHIFT.
REQ-021 SHIFT: on each falling edge, present the next bit: data bits 1..7 LSB first, then parity, then stop (data_drive_low=0); drive_low = NOT bit value.
REQ-022 After the falling edge that releases stop, the FSM SHALL enter ACK.
REQ-023 ACK: on the next falling edge, sample synchronised data; 0 moves to WAIT_IDLE, 1 pulses tx_error and returns to IDLE.
REQ-024 WAIT_IDLE: when synchronised clock=1 and data=1, pulse tx_done and return to IDLE.
REQ-025 The drive outputs SHALL update on the cycle after falling-edge detection, within 4 clk_in cycles of the pin edge.
REQ-026 A timeout counter SHALL clear on entry to REQUEST and on every falling edge, and count in REQUEST, SHIFT, ACK and WAIT_IDLE.
REQ-027 On reaching TIMEOUT_CYCLES, the block SHALL release both lines, pulse tx_error and go to IDLE; timeout takes priority over a coincident falling edge.
REQ-028 busy=1 in every state except IDLE.
REQ-029 tx_valid SHALL be ignored while busy; tx_done and tx_error SHALL never assert on the same cycle.
REQ-030 Falling edges arriving in IDLE or INHIBIT SHALL be ignored.

Reset
REQ-031 While reset_n=0: state=IDLE, ps2_clock_drive_low=0, ps2_data_drive_low=0, busy=0, tx_ready=1, tx_done=0, tx_error=0, counters=0, synchronisers=1.
REQ-032 Reset asserted mid-transfer SHALL release both lines immediately (asynchronously) and SHALL NOT produce tx_done or tx_error.

Verification (bench parameters INHIBIT_CYCLES=20, TIMEOUT_CYCLES=400)
REQ-033 Send 0xED with a device model that clocks at 40-cycle half-periods and sends ACK -> clock held low 20 cycles; bits observed on rising edges: 0,1,0,1,1,0,1,1,1,parity 1,stop 1; one tx_done pulse; tx_ready back to 1.
REQ-034 Send 0x00 -> parity bit 1; send 0xFF -> parity bit 1; send 0x01 -> parity bit 0.
REQ-035 Device model never clocks after the request -> tx_error pulses 400 cycles after entry to REQUEST, both drive outputs 0, no tx_done.
REQ-036 Device leaves data high on the 11th falling edge -> tx_error pulse, IDLE, lines released.
REQ-037 Assert reset_n=0 during bit 4 -> both drive outputs 0 in the same cycle, no pulses; after release, a new 0xF4 transfer completes normally.
REQ-038 tx_valid held high across a transfer with tx_data changed mid-transfer -> originally latched byte transmitted unaltered; next byte accepted only after return to IDLE.
